// File: rtl/mem_access_unit.sv
// mem_access_unit: load/store sequencer between the core memory stage and a
// word-organised data RAM. Word-crossing loads become two word reads,
// misaligned stores become byte stores, and load data is extracted and extended.
//
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   req_valid/req_ready        request handshake (ready only while idle)
//   req_we, req_funct3         store/load select and RV32 width/sign code
//   req_addr, req_wdata        byte address, low-aligned store data
//   resp_valid                 one-cycle completion pulse
//   resp_rdata, resp_err       extended load data / error flag, held between responses
//   ram_we, ram_funct3         RAM write enable and lane select (SB/SH/SW)
//   ram_addr, ram_wdata        RAM byte address and low-aligned write data
//   ram_rdata                  RAM combinational read of word ram_addr[31:2]
module mem_access_unit #(
  parameter int unsigned ALLOW_MISALIGNED = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        ram_we,
  output logic [2:0]  ram_funct3,
  output logic [31:0] ram_addr,
  output logic [31:0] ram_wdata,
  input  logic [31:0] ram_rdata
);

  localparam int unsigned DW = 32;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ACCESS,
    S_LOAD_HI,
    S_STORE_BYTE,
    S_RESP,
    S_ERR
  } state_t;

  state_t        state;
  logic          we_q;
  logic          cross_q;
  logic [2:0]    f3_q;
  logic [DW-1:0] addr_q;
  logic [DW-1:0] wdata_q;
  logic [DW-1:0] lo_q;
  logic [1:0]    k_q;
  logic          ram_we_q;

  logic          req_f3_ok;
  logic          req_mis;
  logic [DW-1:0] lo_shift;
  logic [DW-1:0] pair_shift;
  logic [1:0]    k_next;
  logic [1:0]    k_last;
  logic [7:0]    byte_next;

  // Sign/zero extension of the low-aligned load value.
  function automatic logic [DW-1:0] extend(input logic [2:0] f3, input logic [DW-1:0] d);
    case (f3)
      F3_B:    extend = {{24{d[7]}}, d[7:0]};
      F3_H:    extend = {{16{d[15]}}, d[15:0]};
      F3_BU:   extend = {24'd0, d[7:0]};
      F3_HU:   extend = {16'd0, d[15:0]};
      default: extend = d;
    endcase
  endfunction

  // Request decode: funct3 legality and misalignment (crossing for loads).
  always_comb begin
    req_f3_ok = 1'b0;
    req_mis   = 1'b0;
    if (req_we) begin
      req_f3_ok = (req_funct3 == F3_B) || (req_funct3 == F3_H) || (req_funct3 == F3_W);
      req_mis   = ((req_funct3 == F3_H) && req_addr[0]) ||
                  ((req_funct3 == F3_W) && (req_addr[1:0] != 2'b00));
    end else begin
      req_f3_ok = (req_funct3 == F3_B) || (req_funct3 == F3_H) || (req_funct3 == F3_W) ||
                  (req_funct3 == F3_BU) || (req_funct3 == F3_HU);
      req_mis   = (((req_funct3 == F3_H) || (req_funct3 == F3_HU)) && (req_addr[1:0] == 2'b11)) ||
                  ((req_funct3 == F3_W) && (req_addr[1:0] != 2'b00));
    end
  end

  // Load alignment shifts and byte-store sequencing helpers.
  assign lo_shift   = ram_rdata >> {addr_q[1:0], 3'b000};
  assign pair_shift = DW'({ram_rdata, lo_q} >> {addr_q[1:0], 3'b000});
  assign k_next     = k_q + 2'd1;
  assign k_last     = (f3_q == F3_H) ? 2'd1 : 2'd3;
  assign byte_next  = 8'(wdata_q >> {k_next, 3'b000});

  // Ready and write enable are both suppressed in any reset cycle.
  assign req_ready = (state == S_IDLE) && !reset;
  assign ram_we    = ram_we_q && !reset;

  // Sequencer: state, latched request and registered RAM/response outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      we_q       <= 1'b0;
      cross_q    <= 1'b0;
      f3_q       <= 3'b000;
      addr_q     <= '0;
      wdata_q    <= '0;
      lo_q       <= '0;
      k_q        <= 2'd0;
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      resp_rdata <= '0;
      ram_we_q   <= 1'b0;
      ram_funct3 <= F3_W;
      ram_addr   <= '0;
      ram_wdata  <= '0;
    end else begin
      resp_valid <= 1'b0;
      ram_we_q   <= 1'b0;
      ram_funct3 <= F3_W;
      ram_wdata  <= '0;
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            we_q    <= req_we;
            f3_q    <= req_funct3;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            cross_q <= req_mis && !req_we;
            if (!req_f3_ok || (req_mis && (ALLOW_MISALIGNED == 0))) begin
              state <= S_ERR;
            end else if (req_mis && req_we) begin
              state      <= S_STORE_BYTE;
              k_q        <= 2'd0;
              ram_we_q   <= 1'b1;
              ram_funct3 <= F3_B;
              ram_addr   <= req_addr;
              ram_wdata  <= {24'd0, req_wdata[7:0]};
            end else begin
              state    <= S_ACCESS;
              ram_addr <= req_addr;
              if (req_we) begin
                ram_we_q   <= 1'b1;
                ram_funct3 <= req_funct3;
                ram_wdata  <= req_wdata;
              end
            end
          end
        end
        S_ACCESS: begin
          if (we_q) begin
            state      <= S_RESP;
            resp_valid <= 1'b1;
            resp_err   <= 1'b0;
            resp_rdata <= '0;
          end else if (cross_q) begin
            state    <= S_LOAD_HI;
            lo_q     <= ram_rdata;
            ram_addr <= {addr_q[31:2], 2'b00} + DW'(4);
          end else begin
            state      <= S_RESP;
            resp_valid <= 1'b1;
            resp_err   <= 1'b0;
            resp_rdata <= extend(f3_q, lo_shift);
          end
        end
        S_LOAD_HI: begin
          state      <= S_RESP;
          resp_valid <= 1'b1;
          resp_err   <= 1'b0;
          resp_rdata <= extend(f3_q, pair_shift);
        end
        S_STORE_BYTE: begin
          if (k_q == k_last) begin
            state      <= S_RESP;
            k_q        <= 2'd0;
            resp_valid <= 1'b1;
            resp_err   <= 1'b0;
            resp_rdata <= '0;
          end else begin
            k_q        <= k_next;
            ram_we_q   <= 1'b1;
            ram_funct3 <= F3_B;
            ram_addr   <= addr_q + DW'(k_next);
            ram_wdata  <= {24'd0, byte_next};
          end
        end
        // Error takes one internal cycle so it reports with the same latency as an access.
        S_ERR: begin
          state      <= S_RESP;
          resp_valid <= 1'b1;
          resp_err   <= 1'b1;
          resp_rdata <= '0;
        end
        S_RESP: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
module tb_mem_access_unit;

  typedef struct packed {
    logic        err;
    logic [31:0] rdata;
    logic [7:0]  lat;
  } resp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        req_valid, req_valid0, req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;

  logic        req_ready, resp_valid, resp_err, ram_we;
  logic [31:0] resp_rdata, ram_addr, ram_wdata, ram_rdata;
  logic [2:0]  ram_funct3;

  logic        req_ready0, resp_valid0, resp_err0, ram_we0;
  logic [31:0] resp_rdata0, ram_addr0, ram_wdata0, ram_rdata0;
  logic [2:0]  ram_funct30;

  logic [31:0] mem [0:63];
  logic        tb_we = 1'b0;
  logic [5:0]  tb_idx = 6'd0;
  logic [31:0] tb_val = 32'd0;

  int          cyc = 0;
  int          n_checks = 0;
  int          n_fail = 0;

  logic [66:0] obs_wr [0:63];
  int          obs_cyc [0:63];
  int          obs_n = 0;
  int          obs0_n = 0;

  resp_t       exp_resp [$];
  logic [66:0] exp_wr [$];

  mem_access_unit dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .ram_we(ram_we), .ram_funct3(ram_funct3), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  mem_access_unit #(.ALLOW_MISALIGNED(0)) dut0 (
    .clk(clk), .reset(reset),
    .req_valid(req_valid0), .req_ready(req_ready0), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid0), .resp_rdata(resp_rdata0), .resp_err(resp_err0),
    .ram_we(ram_we0), .ram_funct3(ram_funct30), .ram_addr(ram_addr0),
    .ram_wdata(ram_wdata0), .ram_rdata(ram_rdata0)
  );

  assign ram_rdata  = mem[ram_addr[7:2]];
  assign ram_rdata0 = mem[ram_addr0[7:2]];

  always @(posedge clk) cyc <= cyc + 1;

  // RAM model: byte, half and word lanes; bench preload port has priority.
  always @(posedge clk) begin
    if (tb_we) begin
      mem[tb_idx] <= tb_val;
    end else if (ram_we) begin
      case (ram_funct3)
        3'b000:  mem[ram_addr[7:2]][{ram_addr[1:0], 3'b000} +: 8] <= ram_wdata[7:0];
        3'b001:  mem[ram_addr[7:2]][{ram_addr[1], 4'b0000} +: 16] <= ram_wdata[15:0];
        default: mem[ram_addr[7:2]] <= ram_wdata;
      endcase
    end
  end

  // Write monitor: record every RAM write with the cycle it occurred in.
  always @(negedge clk) begin
    if (ram_we && obs_n < 64) begin
      obs_wr[obs_n]  = {ram_funct3, ram_addr, ram_wdata};
      obs_cyc[obs_n] = cyc;
      obs_n          = obs_n + 1;
    end
    if (ram_we0) obs0_n = obs0_n + 1;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic poke(input logic [5:0] idx, input logic [31:0] val);
    @(negedge clk);
    tb_we = 1'b1; tb_idx = idx; tb_val = val;
    @(negedge clk);
    tb_we = 1'b0;
  endtask

  // Drive one request for one cycle and wait (bounded) for its response.
  task automatic run_req(input logic sel0, input logic we, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wd,
                         output logic [31:0] rd, output logic err,
                         output int c, output int rc, output logic to);
    @(negedge clk);
    req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
    if (sel0) req_valid0 = 1'b1; else req_valid = 1'b1;
    c = cyc;
    @(posedge clk);
    #1;
    req_valid = 1'b0; req_valid0 = 1'b0;
    to = 1'b1; rd = 32'hx; err = 1'bx; rc = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (sel0 ? resp_valid0 : resp_valid) begin
        rd  = sel0 ? resp_rdata0 : resp_rdata;
        err = sel0 ? resp_err0 : resp_err;
        rc  = cyc;
        to  = 1'b0;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; req_valid = 1'b0; req_valid0 = 1'b0;
    req_we = 1'b0; req_funct3 = 3'b000; req_addr = '0; req_wdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if ({req_ready, resp_valid, resp_err, ram_we} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_ctrl: ready/valid/err/we=%b required 0000", {req_ready, resp_valid, resp_err, ram_we});
    end
    n_checks++;
    if (resp_rdata !== 32'd0) begin
      n_fail++; $display("FAIL reset_rdata: got %h required 00000000", resp_rdata);
    end
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    n_checks++;
    if (req_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_ready_after: got %b required 1", req_ready);
    end
  endtask

  task automatic test_loads();
    logic [2:0]  f3s  [8] = '{3'b000, 3'b000, 3'b100, 3'b010, 3'b001, 3'b101, 3'b001, 3'b010};
    logic [31:0] ads  [8] = '{32'h13, 32'h17, 32'h17, 32'h12, 32'h13, 32'h11, 32'h16, 32'hFFFF_FFFE};
    logic [31:0] exps [8] = '{32'h0000_0044, 32'hFFFF_FF88, 32'h0000_0088, 32'h6655_4433,
                              32'h0000_5544, 32'h0000_3322, 32'hFFFF_8877, 32'h3344_AABB};
    logic [7:0]  lats [8] = '{8'd2, 8'd2, 8'd2, 8'd3, 8'd3, 8'd2, 8'd2, 8'd3};
    logic [31:0] rd; logic err, to; int c, rc, base; resp_t e;
    for (int i = 0; i < 8; i++) begin
      exp_resp.push_back('{err: 1'b0, rdata: exps[i], lat: lats[i]});
      base = obs_n;
      run_req(1'b0, 1'b0, f3s[i], ads[i], 32'h0, rd, err, c, rc, to);
      e = exp_resp.pop_front();
      n_checks++;
      if (to) begin
        n_fail++; $display("FAIL load%0d_timeout: no resp_valid within 20 cycles", i);
      end else if ({err, rd} !== {e.err, e.rdata}) begin
        n_fail++; $display("FAIL load%0d_data: err/rdata=%b/%h required %b/%h", i, err, rd, e.err, e.rdata);
      end
      n_checks++;
      if (8'(rc - c) !== e.lat) begin
        n_fail++; $display("FAIL load%0d_latency: got %0d required %0d", i, rc - c, e.lat);
      end
      n_checks++;
      if (obs_n !== base) begin
        n_fail++; $display("FAIL load%0d_nowrite: %0d writes seen required 0", i, obs_n - base);
      end
    end
    repeat (2) @(negedge clk);
    n_checks++;
    if ({resp_valid, resp_rdata} !== {1'b0, 32'h3344_AABB}) begin
      n_fail++; $display("FAIL load_hold: valid/rdata=%b/%h required 0/3344aabb", resp_valid, resp_rdata);
    end
  endtask

  task automatic test_errors();
    logic        wes [3] = '{1'b0, 1'b1, 1'b1};
    logic [2:0]  f3s [3] = '{3'b011, 3'b100, 3'b011};
    logic [31:0] ads [3] = '{32'h10, 32'h20, 32'h24};
    logic [31:0] rd; logic err, to; int c, rc, base, base0; resp_t e;
    for (int i = 0; i < 3; i++) begin
      exp_resp.push_back('{err: 1'b1, rdata: 32'h0, lat: 8'd2});
      base = obs_n;
      run_req(1'b0, wes[i], f3s[i], ads[i], 32'hFFFF_FFFF, rd, err, c, rc, to);
      e = exp_resp.pop_front();
      n_checks++;
      if (to || {err, rd, 8'(rc - c)} !== {e.err, e.rdata, e.lat}) begin
        n_fail++; $display("FAIL err%0d: to=%b err/rdata/lat=%b/%h/%0d required %b/%h/%0d",
                           i, to, err, rd, rc - c, e.err, e.rdata, e.lat);
      end
      n_checks++;
      if (obs_n !== base) begin
        n_fail++; $display("FAIL err%0d_nowrite: %0d writes seen required 0", i, obs_n - base);
      end
      @(negedge clk);
      n_checks++;
      if ({resp_valid, req_ready} !== 2'b01) begin
        n_fail++; $display("FAIL err%0d_after: valid/ready=%b required 01", i, {resp_valid, req_ready});
      end
    end
    // Instance with misalignment disabled: crossing LW rejected, aligned LW works.
    base0 = obs0_n;
    exp_resp.push_back('{err: 1'b1, rdata: 32'h0, lat: 8'd2});
    exp_resp.push_back('{err: 1'b0, rdata: 32'h4433_2211, lat: 8'd2});
    for (int i = 0; i < 2; i++) begin
      run_req(1'b1, 1'b0, 3'b010, (i == 0) ? 32'h12 : 32'h10, 32'h0, rd, err, c, rc, to);
      e = exp_resp.pop_front();
      n_checks++;
      if (to || {err, rd, 8'(rc - c)} !== {e.err, e.rdata, e.lat}) begin
        n_fail++; $display("FAIL nomis%0d: to=%b err/rdata/lat=%b/%h/%0d required %b/%h/%0d",
                           i, to, err, rd, rc - c, e.err, e.rdata, e.lat);
      end
    end
    n_checks++;
    if (obs0_n !== base0) begin
      n_fail++; $display("FAIL nomis_nowrite: %0d writes seen required 0", obs0_n - base0);
    end
  endtask

  task automatic test_stores();
    logic [2:0] f3; logic [31:0] a, wd, m8, m9, rd; logic [7:0] lat;
    logic err, to; int c, rc, base, nexp; resp_t e; logic [66:0] w;
    poke(6'd8, 32'h0);
    poke(6'd9, 32'h0);
    for (int i = 0; i < 4; i++) begin
      case (i)
        0: begin
          f3 = 3'b001; a = 32'h22; wd = 32'h0000_1234; lat = 8'd2;
          exp_wr.push_back({3'b001, 32'h22, 32'h0000_1234});
          m8 = 32'h1234_0000; m9 = 32'h0;
        end
        1: begin
          f3 = 3'b010; a = 32'h21; wd = 32'hDEAD_BEEF; lat = 8'd5;
          exp_wr.push_back({3'b000, 32'h21, 32'hEF});
          exp_wr.push_back({3'b000, 32'h22, 32'hBE});
          exp_wr.push_back({3'b000, 32'h23, 32'hAD});
          exp_wr.push_back({3'b000, 32'h24, 32'hDE});
          m8 = 32'hADBE_EF00; m9 = 32'h0000_00DE;
        end
        2: begin
          f3 = 3'b001; a = 32'h25; wd = 32'h0000_CAFE; lat = 8'd3;
          exp_wr.push_back({3'b000, 32'h25, 32'hFE});
          exp_wr.push_back({3'b000, 32'h26, 32'hCA});
          m8 = 32'hADBE_EF00; m9 = 32'h00CA_FEDE;
        end
        default: begin
          f3 = 3'b000; a = 32'h20; wd = 32'hFFFF_FF77; lat = 8'd2;
          exp_wr.push_back({3'b000, 32'h20, 32'hFFFF_FF77});
          m8 = 32'hADBE_EF77; m9 = 32'h00CA_FEDE;
        end
      endcase
      exp_resp.push_back('{err: 1'b0, rdata: 32'h0, lat: lat});
      nexp = exp_wr.size();
      base = obs_n;
      run_req(1'b0, 1'b1, f3, a, wd, rd, err, c, rc, to);
      e = exp_resp.pop_front();
      n_checks++;
      if (to || {err, rd, 8'(rc - c)} !== {e.err, e.rdata, e.lat}) begin
        n_fail++; $display("FAIL store%0d_resp: to=%b err/rdata/lat=%b/%h/%0d required %b/%h/%0d",
                           i, to, err, rd, rc - c, e.err, e.rdata, e.lat);
      end
      n_checks++;
      if (obs_n - base != nexp) begin
        n_fail++; $display("FAIL store%0d_wcount: %0d writes required %0d", i, obs_n - base, nexp);
      end
      for (int j = 0; j < nexp; j++) begin
        w = exp_wr.pop_front();
        n_checks++;
        if (obs_wr[base + j] !== w || obs_cyc[base + j] != c + 1 + j) begin
          n_fail++; $display("FAIL store%0d_write%0d: f3/addr/data=%h cyc=%0d required %h cyc=%0d",
                             i, j, obs_wr[base + j], obs_cyc[base + j], w, c + 1 + j);
        end
      end
      n_checks++;
      if ({mem[8], mem[9]} !== {m8, m9}) begin
        n_fail++; $display("FAIL store%0d_mem: mem20/24=%h/%h required %h/%h", i, mem[8], mem[9], m8, m9);
      end
    end
  endtask

  task automatic test_back_to_back();
    int c; resp_t e; logic exp_rdy, exp_vld;
    exp_resp.push_back('{err: 1'b0, rdata: 32'h44, lat: 8'd2});
    exp_resp.push_back('{err: 1'b0, rdata: 32'h44, lat: 8'd5});
    @(negedge clk);
    req_we = 1'b0; req_funct3 = 3'b000; req_addr = 32'h13; req_wdata = 32'h0;
    req_valid = 1'b1;
    c = cyc;
    for (int i = 0; i < 7; i++) begin
      if (i > 0) @(negedge clk);
      exp_rdy = (i == 0) || (i == 3) || (i == 6);
      exp_vld = (i == 2) || (i == 5);
      n_checks++;
      if ({req_ready, resp_valid} !== {exp_rdy, exp_vld}) begin
        n_fail++; $display("FAIL b2b_cycle%0d: ready/valid=%b required %b", i, {req_ready, resp_valid}, {exp_rdy, exp_vld});
      end
      if (resp_valid && exp_resp.size() > 0) begin
        e = exp_resp.pop_front();
        n_checks++;
        if ({resp_err, resp_rdata, 8'(cyc - c)} !== {e.err, e.rdata, e.lat}) begin
          n_fail++; $display("FAIL b2b_resp: err/rdata/lat=%b/%h/%0d required %b/%h/%0d",
                             resp_err, resp_rdata, cyc - c, e.err, e.rdata, e.lat);
        end
      end
      if (i == 3) begin
        @(posedge clk);
        #1 req_valid = 1'b0;
      end
    end
    n_checks++;
    if (exp_resp.size() != 0) begin
      n_fail++; $display("FAIL b2b_count: %0d responses missing required 0", exp_resp.size());
      exp_resp.delete();
    end
  endtask

  task automatic test_reset_mid();
    int base; logic [66:0] w; logic [31:0] rd; logic err, to; int c, rc; resp_t e;
    poke(6'd8, 32'h0);
    poke(6'd9, 32'h0);
    exp_wr.push_back({3'b000, 32'h21, 32'hEF});
    exp_wr.push_back({3'b000, 32'h22, 32'hBE});
    base = obs_n;
    @(negedge clk);
    req_we = 1'b1; req_funct3 = 3'b010; req_addr = 32'h21; req_wdata = 32'hDEAD_BEEF;
    req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({ram_we, req_ready, resp_valid} !== 3'b000) begin
      n_fail++; $display("FAIL rstmid_during: we/ready/valid=%b required 000", {ram_we, req_ready, resp_valid});
    end
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({req_ready, resp_valid} !== 2'b10) begin
      n_fail++; $display("FAIL rstmid_after: ready/valid=%b required 10", {req_ready, resp_valid});
    end
    repeat (3) begin
      @(negedge clk);
      n_checks++;
      if (resp_valid !== 1'b0) begin
        n_fail++; $display("FAIL rstmid_noresp: resp_valid=%b required 0", resp_valid);
      end
    end
    n_checks++;
    if (obs_n - base != 2) begin
      n_fail++; $display("FAIL rstmid_wcount: %0d writes required 2", obs_n - base);
    end
    for (int j = 0; j < 2; j++) begin
      w = exp_wr.pop_front();
      n_checks++;
      if (obs_wr[base + j] !== w) begin
        n_fail++; $display("FAIL rstmid_write%0d: %h required %h", j, obs_wr[base + j], w);
      end
    end
    n_checks++;
    if ({mem[8], mem[9]} !== {32'h00BE_EF00, 32'h0}) begin
      n_fail++; $display("FAIL rstmid_mem: mem20/24=%h/%h required 00beef00/00000000", mem[8], mem[9]);
    end
    exp_resp.push_back('{err: 1'b0, rdata: 32'h4433_2211, lat: 8'd2});
    run_req(1'b0, 1'b0, 3'b010, 32'h10, 32'h0, rd, err, c, rc, to);
    e = exp_resp.pop_front();
    n_checks++;
    if (to || {err, rd, 8'(rc - c)} !== {e.err, e.rdata, e.lat}) begin
      n_fail++; $display("FAIL rstmid_lw: to=%b err/rdata/lat=%b/%h/%0d required %b/%h/%0d",
                         to, err, rd, rc - c, e.err, e.rdata, e.lat);
    end
  endtask

  initial begin
    test_reset();
    poke(6'd4,  32'h4433_2211);
    poke(6'd5,  32'h8877_6655);
    poke(6'd63, 32'hAABB_CCDD);
    poke(6'd0,  32'h1122_3344);
    test_loads();
    test_errors();
    test_stores();
    test_back_to_back();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Load/store sequencer between the multi-cycle core's memory stage and the word-organised data RAM. It accepts one load or store per handshake and performs the access in one or more RAM cycles. Word-crossing loads are split into two word reads. Misaligned stores are split into byte stores. Load results are extracted and sign- or zero-extended, and a registered response is returned to the core.

## Interface
Parameters:
- ALLOW_MISALIGNED, default 1. 1: split misaligned accesses. 0: reject them with resp_err.

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  unit idle; request accepted when req_valid && req_ready
- req_we  in  1  1 = store, 0 = load
- req_funct3  in  3  RV32 load/store funct3
- req_addr  in  32  byte address
- req_wdata  in  32  store data (low-aligned)
- resp_valid  out  1  one-cycle pulse: request completed
- resp_rdata  out  32  extended load data; 0 for stores and errors
- resp_err  out  1  valid with resp_valid: invalid funct3, or misaligned with ALLOW_MISALIGNED=0
- ram_we  out  1  RAM write enable
- ram_funct3  out  3  RAM lane select (000 SB, 001 SH, 010 SW)
- ram_addr  out  32  RAM byte address
- ram_wdata  out  32  RAM write data, low-aligned
- ram_rdata  in  32  RAM combinational read of word ram_addr[31:2]

## Operation
Request latching:
- All req_* fields are latched on acceptance and ignored afterwards.
- Valid load funct3: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
- Valid store funct3: 000 SB, 001 SH, 010 SW.
- Any other funct3 → ERR.

Misalignment rules (o = addr[1:0]):
- Load word-crossing: LH/LHU with o==3; LW with o!=0.
- Store misaligned: SH with o[0]==1; SW with o!=0.
- A misaligned SH with o==1 still splits; the RAM SH path uses addr[1] only.

States: IDLE, ACCESS, LOAD_HI, STORE_BYTE, RESP, ERR.
- IDLE: req_ready=1. On acceptance:
  - invalid funct3, or misaligned with ALLOW_MISALIGNED=0 → ERR
  - misaligned store → STORE_BYTE with k=0
  - otherwise → ACCESS
- ACCESS: ram_addr = addr.
  - Store: ram_we=1, ram_funct3=latched funct3, ram_wdata=wdata → RESP.
  - Non-crossing load: shift ram_rdata right by 8*o, extend, register → RESP.
  - Crossing load: latch ram_rdata as lo → LOAD_HI.
- LOAD_HI: ram_addr = {addr[31:2],2'b00}+4, mod 2^32 (0xFFFFFFFC wraps to 0). Form {ram_rdata, lo} >> 8*o, take low 16/32 bits, extend, register → RESP.
- STORE_BYTE: ram_we=1, ram_funct3=000, ram_addr=addr+k (mod 2^32), ram_wdata[7:0]=wdata byte k. k counts 0..N-1 with N=2 (SH) or 4 (SW). After k=N-1 → RESP.
- RESP: resp_valid=1 → IDLE.
- ERR: resp_valid=1, resp_err=1, resp_rdata=0, no RAM access → IDLE.

Extension:
- LB/LH sign-extend from bit 7/15.
- LBU/LHU zero-extend.
- LW unchanged.

RAM outputs outside write states:
- ram_we=0, ram_funct3=010, ram_wdata=0.
- ram_addr holds the last driven value (don't-care).

## Timing
Latency, with acceptance in cycle c:
- aligned/non-crossing: resp_valid at c+2
- crossing load: c+3
- split SH store: c+3
- split SW store: c+5
- error: c+2
- req_ready returns the cycle after resp_valid.

Outputs:
- resp_rdata/resp_err are registered and held until the next resp_valid.
- ram_we is combinationally gated by !reset, so no RAM write occurs in any cycle where reset=1.

Reset:
- State → IDLE, k=0, resp_valid=0, resp_err=0, resp_rdata=0.
- req_ready=0 while reset=1; it is 1 the first cycle after reset deasserts.
- Reset mid-sequence aborts the request. Byte writes completed before the reset cycle persist. No response is produced.
- req_valid during a busy state is not accepted and not lost by the unit; the requester holds it.

## Test plan
Preload mem[0x10]=0x44332211, mem[0x14]=0x88776655.
- LB 0x13 → 0x00000044, resp_valid at c+2. LB 0x17 → 0xFFFFFF88. LBU 0x17 → 0x00000088.
- LW 0x12 → reads 0x10 then 0x14; resp 0x66554433 at c+3. LH 0x13 → 0x00005544. LHU 0x11 → 0x00003322 at c+2 (no split).
- mem[0x20]=mem[0x24]=0; SW 0x21 data 0xDEADBEEF:
  - expect SB 0x21/EF, 0x22/BE, 0x23/AD, 0x24/DE on consecutive cycles
  - then mem[0x20]=0xADBEEF00, mem[0x24]=0x000000DE, resp at c+5.
- Aligned SH 0x22 data 0x1234 → single cycle, ram_funct3=001, ram_addr=0x22; then mem[0x20]=0x12340000 (starting from 0).
- Error cases, resp_err=1, rdata 0, no ram_we, resp at c+2:
  - ALLOW_MISALIGNED=0: LW 0x12
  - any setting: load funct3=011
  - store funct3=100
- Reset during the third STORE_BYTE cycle of SW 0x21:
  - only 0x21 and 0x22 are written; ram_we=0 in the reset cycle
  - no resp_valid
  - req_ready=1 the cycle after reset deasserts
  - a following LW 0x10 completes normally.
